if_fetch_ctrl: RTL and testbench

Instruction-fetch controller that generates the fetch PC, drives the instruction-SRAM-like bus (req/addr_ok/data_ok), and feeds the IF→ID pipeline register through a valid/ready handshake. It owns branch redirection: in-flight fetches are cancelled, stale responses are dropped, and fetch restarts at the branch target. One request is outstanding at a time, and a single-entry buffer holds the returned instruction until ID accepts it.

---
 rtl/if_fetch_ctrl_if.sv | 23 ++
 rtl/if_fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_if_fetch_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-bus and IF->ID handshake bundle for the fetch controller.
// The master side is the controller; the slave side is the bus and the ID stage.
interface if_fetch_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        o_if_valid;
  logic        i_if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  modport master (
    output inst_req, inst_addr, o_if_valid, if_pc, if_inst,
    input  inst_addr_ok, inst_data_ok, inst_rdata, i_if_ready
  );

  modport slave (
    input  inst_req, inst_addr, o_if_valid, if_pc, if_inst,
    output inst_addr_ok, inst_data_ok, inst_rdata, i_if_ready
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: one outstanding bus request, single-entry
// instruction buffer toward IF->ID, branch redirect with stale-response drop.
//
// state | meaning
// IDLE  | just out of reset, request starts next cycle
// REQ   | inst_req high at fetch_pc, waiting for addr_ok
// WAIT  | one accepted request outstanding, waiting for data_ok
// HOLD  | buffer full, o_if_valid high until ID accepts or a branch flushes it
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_taken,
  input  logic [31:0]     br_target,
  if_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        discard_q, discard_d;
  logic        redir_pend_q, redir_pend_d;
  logic        inst_req_q, inst_req_d;
  logic        if_valid_q, if_valid_d;

  logic [31:0] br_tgt_w;
  logic [31:0] newest_tgt;
  logic        redir_any;

  assign br_tgt_w   = br_target & ~32'd3;
  // A redirect arriving this cycle supersedes one parked while addr_ok was low.
  assign newest_tgt = br_taken ? br_tgt_w : redir_pc_q;
  assign redir_any  = redir_pend_q | br_taken;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    redir_pc_d   = redir_pc_q;
    buf_pc_d     = buf_pc_q;
    buf_inst_d   = buf_inst_q;
    discard_d    = discard_q;
    redir_pend_d = redir_pend_q;

    case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        if (bus.inst_addr_ok) begin
          state_d   = WAIT;
          discard_d = redir_any;
          if (redir_any) begin
            fetch_pc_d   = newest_tgt;
            redir_pend_d = 1'b0;
          end
        end else if (br_taken) begin
          // inst_addr must not move while inst_req is high, so park the target.
          redir_pend_d = 1'b1;
          redir_pc_d   = br_tgt_w;
        end
      end

      WAIT: begin
        if (bus.inst_data_ok) begin
          if (discard_q || br_taken) begin
            discard_d = 1'b0;
            state_d   = REQ;
            if (br_taken) fetch_pc_d = br_tgt_w;
          end else begin
            buf_pc_d   = fetch_pc_q;
            buf_inst_d = bus.inst_rdata;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = HOLD;
          end
        end else if (br_taken) begin
          discard_d  = 1'b1;
          fetch_pc_d = br_tgt_w;
        end
      end

      HOLD: begin
        if (br_taken) begin
          fetch_pc_d = br_tgt_w;
          state_d    = REQ;
        end else if (bus.i_if_ready) begin
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase

    inst_req_d = (state_d == REQ);
    if_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      redir_pc_q   <= RESET_PC;
      buf_pc_q     <= RESET_PC;
      buf_inst_q   <= '0;
      discard_q    <= 1'b0;
      redir_pend_q <= 1'b0;
      inst_req_q   <= 1'b0;
      if_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      redir_pc_q   <= redir_pc_d;
      buf_pc_q     <= buf_pc_d;
      buf_inst_q   <= buf_inst_d;
      discard_q    <= discard_d;
      redir_pend_q <= redir_pend_d;
      inst_req_q   <= inst_req_d;
      if_valid_q   <= if_valid_d;
    end
  end

  assign bus.inst_req   = inst_req_q;
  assign bus.inst_addr  = fetch_pc_q;
  assign bus.o_if_valid = if_valid_q;
  assign bus.if_pc      = buf_pc_q;
  assign bus.if_inst    = buf_inst_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: per-scenario tasks drive the bus cycle by
// cycle and compare {inst_req, inst_addr, o_if_valid, if_pc, if_inst}.
`timescale 1ns/1ps
module tb_if_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  logic [97:0] obs;

  if_fetch_ctrl_if bus();

  if_fetch_ctrl #(.RESET_PC(32'h1c00_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .br_taken  (br_taken),
    .br_target (br_target),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.inst_req, bus.inst_addr, bus.o_if_valid, bus.if_pc, bus.if_inst};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [97:0] e;
    rst = 1'b1;
    repeat (3) tick();
    exp_pc   = 32'h1c00_0000;
    exp_inst = 32'h0;
    e = {1'b0, 32'h1c00_0000, 1'b0, 32'h1c00_0000, 32'h0};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL reset_vals got=%h exp=%h", obs, e); end
    rst = 1'b0;
    tick();
    e = {1'b1, 32'h1c00_0000, 1'b0, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL reset_first_req got=%h exp=%h", obs, e); end
  endtask

  task automatic test_zero_wait();
    logic [97:0] e;
    logic [31:0] pc;
    bus.i_if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h1c00_0000 + 32'(4 * i);
      e = {1'b1, pc, 1'b0, exp_pc, exp_inst};
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL zw_req[%0d] got=%h exp=%h", i, obs, e); end
      bus.inst_addr_ok = 1'b1; tick(); bus.inst_addr_ok = 1'b0;
      e = {1'b0, pc, 1'b0, exp_pc, exp_inst};
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL zw_wait[%0d] got=%h exp=%h", i, obs, e); end
      bus.inst_data_ok = 1'b1;
      bus.inst_rdata   = 32'ha000_0000 + 32'(i);
      tick();
      bus.inst_data_ok = 1'b0;
      exp_pc   = pc;
      exp_inst = 32'ha000_0000 + 32'(i);
      e = {1'b0, pc + 32'd4, 1'b1, exp_pc, exp_inst};
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL zw_hold[%0d] got=%h exp=%h", i, obs, e); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [97:0] e;
    bus.i_if_ready = 1'b0;
    bus.inst_addr_ok = 1'b1; tick(); bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hb0b0_0001; tick(); bus.inst_data_ok = 1'b0;
    exp_pc   = 32'h1c00_000c;
    exp_inst = 32'hb0b0_0001;
    for (int k = 0; k < 6; k++) begin
      e = {1'b0, 32'h1c00_0010, 1'b1, exp_pc, exp_inst};
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL bp_hold[%0d] got=%h exp=%h", k, obs, e); end
      if (k < 5) tick();
    end
    bus.i_if_ready = 1'b1; tick(); bus.i_if_ready = 1'b0;
    e = {1'b1, 32'h1c00_0010, 1'b0, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL bp_next_req got=%h exp=%h", obs, e); end
  endtask

  task automatic test_br_wait();
    logic [97:0] e;
    bus.i_if_ready = 1'b1;
    bus.inst_addr_ok = 1'b1; tick(); bus.inst_addr_ok = 1'b0;
    br_taken = 1'b1; br_target = 32'h1c00_0100; tick(); br_taken = 1'b0;
    e = {1'b0, 32'h1c00_0100, 1'b0, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL bw_cancel got=%h exp=%h", obs, e); end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL bw_wait[%0d] got=%h exp=%h", k, obs, e); end
    end
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hdead_beef; tick(); bus.inst_data_ok = 1'b0;
    e = {1'b1, 32'h1c00_0100, 1'b0, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL bw_drop got=%h exp=%h", obs, e); end
    bus.i_if_ready = 1'b0;
  endtask

  task automatic test_br_req();
    logic [97:0] e;
    e = {1'b1, 32'h1c00_0100, 1'b0, exp_pc, exp_inst};
    br_taken = 1'b1; br_target = 32'h1c00_0180; tick(); br_taken = 1'b0;
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL brq_stable1 got=%h exp=%h", obs, e); end
    tick();
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL brq_stable2 got=%h exp=%h", obs, e); end
    br_taken = 1'b1; br_target = 32'h1c00_0200; tick(); br_taken = 1'b0;
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL brq_stable3 got=%h exp=%h", obs, e); end
    bus.inst_addr_ok = 1'b1; tick(); bus.inst_addr_ok = 1'b0;
    e = {1'b0, 32'h1c00_0200, 1'b0, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL brq_accept got=%h exp=%h", obs, e); end
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hbad0_0001; tick(); bus.inst_data_ok = 1'b0;
    e = {1'b1, 32'h1c00_0200, 1'b0, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL brq_drop got=%h exp=%h", obs, e); end
  endtask

  task automatic test_br_hold();
    logic [97:0] e;
    bus.inst_addr_ok = 1'b1; tick(); bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hc0c0_0001; tick(); bus.inst_data_ok = 1'b0;
    exp_pc   = 32'h1c00_0200;
    exp_inst = 32'hc0c0_0001;
    e = {1'b0, 32'h1c00_0204, 1'b1, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL bh_hold got=%h exp=%h", obs, e); end
    bus.i_if_ready = 1'b1; br_taken = 1'b1; br_target = 32'h1c00_0300; tick();
    bus.i_if_ready = 1'b0; br_taken = 1'b0;
    e = {1'b1, 32'h1c00_0300, 1'b0, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL bh_flush got=%h exp=%h", obs, e); end
    bus.inst_addr_ok = 1'b1; tick(); bus.inst_addr_ok = 1'b0;
    e = {1'b0, 32'h1c00_0300, 1'b0, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL bh_wait got=%h exp=%h", obs, e); end
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hd0d0_0001;
    br_taken = 1'b1; br_target = 32'h1c00_0403; tick();
    bus.inst_data_ok = 1'b0; br_taken = 1'b0;
    e = {1'b1, 32'h1c00_0400, 1'b0, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL bh_data_br got=%h exp=%h", obs, e); end
    bus.inst_addr_ok = 1'b1; tick(); bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'he0e0_0001; tick(); bus.inst_data_ok = 1'b0;
    exp_pc   = 32'h1c00_0400;
    exp_inst = 32'he0e0_0001;
    e = {1'b0, 32'h1c00_0404, 1'b1, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL bh_fresh got=%h exp=%h", obs, e); end
    bus.i_if_ready = 1'b1; tick(); bus.i_if_ready = 1'b0;
    e = {1'b1, 32'h1c00_0404, 1'b0, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL bh_next got=%h exp=%h", obs, e); end
  endtask

  task automatic test_wrap_and_reset();
    logic [97:0] e;
    bus.inst_addr_ok = 1'b1; br_taken = 1'b1; br_target = 32'hffff_fffc; tick();
    bus.inst_addr_ok = 1'b0; br_taken = 1'b0;
    e = {1'b0, 32'hffff_fffc, 1'b0, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL wr_accept_br got=%h exp=%h", obs, e); end
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h1111_1111; tick(); bus.inst_data_ok = 1'b0;
    e = {1'b1, 32'hffff_fffc, 1'b0, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL wr_drop got=%h exp=%h", obs, e); end
    bus.inst_addr_ok = 1'b1; tick(); bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hf0f0_0001; tick(); bus.inst_data_ok = 1'b0;
    exp_pc   = 32'hffff_fffc;
    exp_inst = 32'hf0f0_0001;
    e = {1'b0, 32'h0000_0000, 1'b1, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL wr_hold got=%h exp=%h", obs, e); end
    bus.i_if_ready = 1'b1; tick(); bus.i_if_ready = 1'b0;
    e = {1'b1, 32'h0000_0000, 1'b0, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL wr_next got=%h exp=%h", obs, e); end
    bus.inst_addr_ok = 1'b1; tick(); bus.inst_addr_ok = 1'b0;
    rst = 1'b1; tick();
    exp_pc   = 32'h1c00_0000;
    exp_inst = 32'h0;
    e = {1'b0, 32'h1c00_0000, 1'b0, 32'h1c00_0000, 32'h0};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL rm_reset got=%h exp=%h", obs, e); end
    rst = 1'b0; tick();
    e = {1'b1, 32'h1c00_0000, 1'b0, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL rm_restart got=%h exp=%h", obs, e); end
    bus.inst_addr_ok = 1'b1; tick(); bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h1234_5678; tick(); bus.inst_data_ok = 1'b0;
    exp_inst = 32'h1234_5678;
    e = {1'b0, 32'h1c00_0004, 1'b1, exp_pc, exp_inst};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL rm_fetch got=%h exp=%h", obs, e); end
  endtask

  initial begin
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    bus.i_if_ready   = 1'b0;
    exp_pc   = 32'h1c00_0000;
    exp_inst = 32'h0;
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_br_wait();
    test_br_req();
    test_br_hold();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
